// File: rtl/fetch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_if
//   Bundles the fetch unit's control, redirect, instruction-memory and IF/ID
//   signals.
//
//   master : the surrounding core side (hazard unit, ID/EX redirects, imem).
//            It drives stall/branch/jump/imem_rdata.
//   slave  : the fetch_pc_unit itself. It drives imem_addr, the IF/ID
//            register outputs and misalign_err.
// ---------------------------------------------------------------------------
interface fetch_pc_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        misalign_err;

  modport master (
    output stall, branch_taken, branch_target, jump_en, jump_target, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, misalign_err
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump_en, jump_target, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, misalign_err
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   IF-stage program counter plus the IF/ID pipeline register.
//
//   Next PC is selected with this priority:
//     1. taken EX branch
//     2. hazard stall
//     3. ID jump
//     4. sequential PC+4
//   The instruction-memory address is the current PC, driven combinationally.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : synchronous active-low reset
//     bus    : fetch_pc_unit_if.slave
//              - inputs:  stall, branch_taken/target, jump_en/target, imem_rdata
//              - outputs: imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid,
//                         misalign_err
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_pc_unit_if.slave bus
);

  logic [31:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;
  logic        mis_q,   mis_d;
  logic [31:0] pc_plus4;

  // Redirect targets are word-aligned before being loaded into the PC.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Wraps modulo 2^32 naturally.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    mis_d   = 1'b0;
    if (bus.branch_taken) begin
      // A taken branch wins over stall: the stalled ID instruction is
      // wrong-path anyway.
      pc_d    = align_word(bus.branch_target);
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      mis_d   = |bus.branch_target[1:0];
    end else if (bus.stall) begin
      // Hold everything. A jump in ID stays there and is re-presented after
      // the stall clears, so it is ignored here.
    end else if (bus.jump_en) begin
      pc_d    = align_word(bus.jump_target);
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      mis_d   = |bus.jump_target[1:0];
    end else begin
      pc_d    = pc_plus4;
      instr_d = bus.imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // IF/ID pipeline register boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.ifid_instr    = instr_q;
  assign bus.ifid_pc_plus4 = pc4_q;
  assign bus.ifid_valid    = valid_q;
  assign bus.misalign_err  = mis_q;

endmodule
